// File: rtl/spin_dispatch.sv
// spin_dispatch: buffers host spin vectors and loops each through the wrapper's pop/return handshake for a set number of iterations.
// Optional macro SPIN_DISPATCH_EARLY_STOP_EN ends a job early when the returned spin equals the issued spin.
module spin_dispatch #(
  parameter int NUM_SPIN         = 256,
  parameter int COUNTER_BITWIDTH = 16,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic [COUNTER_BITWIDTH-1:0]   cfg_iter_num_i,
  input  logic                          host_valid_i,
  output logic                          host_ready_o,
  input  logic [NUM_SPIN-1:0]           host_spin_i,
  output logic                          spin_pop_valid_o,
  input  logic                          spin_pop_ready_i,
  output logic [NUM_SPIN-1:0]           spin_pop_o,
  input  logic                          spin_valid_i,
  output logic                          spin_ready_o,
  input  logic [NUM_SPIN-1:0]           spin_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [NUM_SPIN-1:0]           res_spin_o,
  output logic [COUNTER_BITWIDTH-1:0]   res_iter_o,
  output logic                          res_converged_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = COUNTER_BITWIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_e;

  state_e                        state_q, state_d;
  logic [NUM_SPIN-1:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [NUM_SPIN-1:0]           cur_spin_q, cur_spin_d;
  logic [COUNTER_BITWIDTH-1:0]   iter_cnt_q, iter_cnt_d, iter_lim_q, iter_lim_d;
  logic                          full, empty, push, pop, last, fixed_pt;

  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign push  = host_valid_i & ~full & ~flush_i;
  assign pop   = (state_q == IDLE) & en_i & ~empty & ~flush_i;
  // widened compare so a saturating counter still meets an all-ones limit
  assign last  = IW'(iter_cnt_q) + IW'(1) == IW'(iter_lim_q);

  always_comb begin
    wr_ptr_d = flush_i ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = flush_i ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d    = state_q;
    cur_spin_d = cur_spin_q;
    iter_cnt_d = iter_cnt_q;
    iter_lim_d = iter_lim_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d    = ISSUE;
        cur_spin_d = mem_q[rd_ptr_q];
        iter_cnt_d = '0;
        iter_lim_d = (cfg_iter_num_i == '0) ? COUNTER_BITWIDTH'(1) : cfg_iter_num_i;
      end
      ISSUE: state_d = spin_pop_ready_i ? WAIT : ISSUE;
      WAIT: if (spin_valid_i) begin
        cur_spin_d = spin_i;
        iter_cnt_d = &iter_cnt_q ? iter_cnt_q : iter_cnt_q + COUNTER_BITWIDTH'(1);
        state_d    = (last | fixed_pt) ? OUTPUT : ISSUE;
      end
      OUTPUT: state_d = res_ready_i ? IDLE : OUTPUT;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d    = IDLE;
      iter_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      cur_spin_q <= '0;
      iter_cnt_q <= '0;
      iter_lim_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      cur_spin_q <= cur_spin_d;
      iter_cnt_q <= iter_cnt_d;
      iter_lim_q <= iter_lim_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= host_spin_i;
  end

`ifdef SPIN_DISPATCH_EARLY_STOP_EN
  logic conv_q, conv_d;
  assign fixed_pt = spin_i == cur_spin_q;
  always_comb begin
    conv_d = flush_i ? 1'b0 :
             ((state_q == WAIT) & spin_valid_i & fixed_pt) ? 1'b1 :
             ((state_q == OUTPUT) & res_ready_i) ? 1'b0 : conv_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) conv_q <= 1'b0;
    else         conv_q <= conv_d;
  end
  assign res_converged_o = conv_q;
`else
  assign fixed_pt        = 1'b0;
  assign res_converged_o = 1'b0;
`endif

  assign host_ready_o     = ~full;
  assign spin_pop_valid_o = state_q == ISSUE;
  assign spin_pop_o       = cur_spin_q;
  assign spin_ready_o     = state_q == WAIT;
  assign res_valid_o      = state_q == OUTPUT;
  assign res_spin_o       = cur_spin_q;
  assign res_iter_o       = iter_cnt_q;
  assign busy_o           = state_q != IDLE;
  assign fifo_cnt_o       = cnt_q;
endmodule

// File: tb/tb_spin_dispatch.sv
// tb_spin_dispatch: directed bench for spin_dispatch with a hand-driven wrapper and result consumer.
module tb_spin_dispatch;
  localparam int NS = 256;
  localparam int CB = 16;
  localparam logic [NS-1:0] VA = {32{8'hA5}};
  localparam logic [NS-1:0] VB = {64{4'h3}};
  localparam logic [NS-1:0] VC = {16{16'h1234}};
  localparam logic [NS-1:0] VD = {8{32'hDEADBEEF}};

  logic clk_i = 1'b0, rst_ni = 1'b0, en_i = 1'b0, flush_i = 1'b0;
  logic [CB-1:0] cfg_iter_num_i = '0;
  logic host_valid_i = 1'b0, spin_pop_ready_i = 1'b0, spin_valid_i = 1'b0, res_ready_i = 1'b0;
  logic [NS-1:0] host_spin_i = '0, spin_i = '0;
  logic host_ready_o, spin_pop_valid_o, spin_ready_o, res_valid_o, res_converged_o, busy_o;
  logic [NS-1:0] spin_pop_o, res_spin_o;
  logic [CB-1:0] res_iter_o;
  logic [2:0] fifo_cnt_o;
  int errors = 0, checks = 0;

  spin_dispatch dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i),
    .cfg_iter_num_i(cfg_iter_num_i),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o), .host_spin_i(host_spin_i),
    .spin_pop_valid_o(spin_pop_valid_o), .spin_pop_ready_i(spin_pop_ready_i), .spin_pop_o(spin_pop_o),
    .spin_valid_i(spin_valid_i), .spin_ready_o(spin_ready_o), .spin_i(spin_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_spin_o(res_spin_o),
    .res_iter_o(res_iter_o), .res_converged_o(res_converged_o),
    .busy_o(busy_o), .fifo_cnt_o(fifo_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [NS-1:0] v);
    host_valid_i = 1'b1;
    host_spin_i  = v;
    @(negedge clk_i);
    host_valid_i = 1'b0;
  endtask

  task automatic do_pop(output logic [NS-1:0] v);
    int n = 0;
    while (spin_pop_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL pop_timeout: spin_pop_valid_o=%b required 1", spin_pop_valid_o);
    end
    v = spin_pop_o;
    spin_pop_ready_i = 1'b1;
    @(negedge clk_i);
    spin_pop_ready_i = 1'b0;
  endtask

  task automatic do_ret(input logic [NS-1:0] v);
    int n = 0;
    while (spin_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL ret_timeout: spin_ready_o=%b required 1", spin_ready_o);
    end
    spin_valid_i = 1'b1;
    spin_i       = v;
    @(negedge clk_i);
    spin_valid_i = 1'b0;
  endtask

  task automatic get_res(output logic [NS-1:0] s, output logic [CB-1:0] it, output logic cv);
    int n = 0;
    while (res_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL res_timeout: res_valid_o=%b required 1", res_valid_o);
    end
    s  = res_spin_o;
    it = res_iter_o;
    cv = res_converged_o;
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (host_ready_o !== 1'b1) begin errors++; $display("FAIL reset_host_ready: got %b exp 1", host_ready_o); end
    checks++; if ({spin_pop_valid_o, spin_ready_o, res_valid_o, res_converged_o, busy_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 00000", {spin_pop_valid_o, spin_ready_o, res_valid_o, res_converged_o, busy_o}); end
    checks++; if (fifo_cnt_o !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", fifo_cnt_o); end
    checks++; if (spin_pop_o !== '0 || res_spin_o !== '0 || res_iter_o !== '0) begin
      errors++; $display("FAIL reset_data: pop %h res %h iter %0d exp all 0", spin_pop_o, res_spin_o, res_iter_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    logic [NS-1:0] p, s;
    logic [CB-1:0] it;
    logic cv;
    cfg_iter_num_i = 16'd1;
    en_i = 1'b1;
    push(VA);
    do_pop(p);
    checks++; if (p !== VA) begin errors++; $display("FAIL basic_pop: got %h exp %h", p, VA); end
    do_ret(VB);
    for (int i = 0; i < 3; i++) begin
      checks++; if (res_valid_o !== 1'b1 || res_spin_o !== VB) begin
        errors++; $display("FAIL basic_hold: valid %b spin %h exp 1 %h", res_valid_o, res_spin_o, VB); end
      @(negedge clk_i);
    end
    get_res(s, it, cv);
    checks++; if (s !== VB) begin errors++; $display("FAIL basic_spin: got %h exp %h", s, VB); end
    checks++; if (it !== 16'd1 || cv !== 1'b0) begin errors++; $display("FAIL basic_iter: iter %0d conv %b exp 1 0", it, cv); end
    checks++; if (busy_o !== 1'b0 || spin_pop_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_idle: busy %b pop_valid %b exp 0 0", busy_o, spin_pop_valid_o); end
  endtask

  task automatic test_multi();
    logic [NS-1:0] p, s;
    logic [CB-1:0] it;
    logic cv;
    cfg_iter_num_i = 16'd3;
    push(VA);
    do_pop(p);
    checks++; if (p !== VA) begin errors++; $display("FAIL multi_pop0: got %h exp %h", p, VA); end
    do_ret(VB);
    do_pop(p);
    checks++; if (p !== VB) begin errors++; $display("FAIL multi_pop1: got %h exp %h", p, VB); end
    do_ret(VC);
    do_pop(p);
    checks++; if (p !== VC) begin errors++; $display("FAIL multi_pop2: got %h exp %h", p, VC); end
    do_ret(VD);
    get_res(s, it, cv);
    checks++; if (s !== VD || it !== 16'd3) begin errors++; $display("FAIL multi_res: spin %h iter %0d exp %h 3", s, it, VD); end
  endtask

  task automatic test_zero();
    logic [NS-1:0] p, s;
    logic [CB-1:0] it;
    logic cv;
    cfg_iter_num_i = 16'd0;
    push(VA);
    do_pop(p);
    do_ret(VB);
    get_res(s, it, cv);
    checks++; if (s !== VB || it !== 16'd1) begin errors++; $display("FAIL zero_res: spin %h iter %0d exp %h 1", s, it, VB); end
  endtask

  task automatic test_fifo_full();
    logic [NS-1:0] v [5];
    logic [NS-1:0] p, s;
    logic [CB-1:0] it;
    logic cv;
    for (int i = 0; i < 5; i++) v[i] = {32{8'(17 * (i + 1))}};
    en_i = 1'b0;
    cfg_iter_num_i = 16'd1;
    for (int i = 0; i < 3; i++) push(v[i]);
    checks++; if (fifo_cnt_o !== 3'd3) begin errors++; $display("FAIL fifo_cnt3: got %0d exp 3", fifo_cnt_o); end
    en_i = 1'b1;
    push(v[3]);
    checks++; if (fifo_cnt_o !== 3'd3 || busy_o !== 1'b1) begin
      errors++; $display("FAIL fifo_pushpop: cnt %0d busy %b exp 3 1", fifo_cnt_o, busy_o); end
    push(v[4]);
    checks++; if (fifo_cnt_o !== 3'd4 || host_ready_o !== 1'b0) begin
      errors++; $display("FAIL fifo_full: cnt %0d ready %b exp 4 0", fifo_cnt_o, host_ready_o); end
    host_valid_i = 1'b1;
    host_spin_i  = '1;
    repeat (2) @(negedge clk_i);
    host_valid_i = 1'b0;
    checks++; if (fifo_cnt_o !== 3'd4) begin errors++; $display("FAIL fifo_stall: cnt %0d exp 4", fifo_cnt_o); end
    for (int i = 0; i < 5; i++) begin
      do_pop(p);
      checks++; if (p !== v[i]) begin errors++; $display("FAIL fifo_order%0d: got %h exp %h", i, p, v[i]); end
      do_ret(~v[i]);
      get_res(s, it, cv);
      checks++; if (s !== ~v[i]) begin errors++; $display("FAIL fifo_res%0d: got %h exp %h", i, s, ~v[i]); end
    end
    checks++; if (fifo_cnt_o !== 3'd0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL fifo_drain: cnt %0d busy %b exp 0 0", fifo_cnt_o, busy_o); end
  endtask

  task automatic test_backpressure();
    logic [NS-1:0] p, s;
    logic [CB-1:0] it;
    logic cv;
    cfg_iter_num_i = 16'd2;
    en_i = 1'b1;
    push(VA);
    @(negedge clk_i);
    for (int i = 0; i < 10; i++) begin
      checks++; if (spin_pop_valid_o !== 1'b1 || spin_pop_o !== VA) begin
        errors++; $display("FAIL bp_pop_hold%0d: valid %b spin %h exp 1 %h", i, spin_pop_valid_o, spin_pop_o, VA); end
      @(negedge clk_i);
    end
    do_pop(p);
    checks++; if (p !== VA) begin errors++; $display("FAIL bp_pop: got %h exp %h", p, VA); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (spin_pop_valid_o !== 1'b0 || spin_ready_o !== 1'b1) begin
        errors++; $display("FAIL bp_no_dup%0d: pop_valid %b spin_ready %b exp 0 1", i, spin_pop_valid_o, spin_ready_o); end
      @(negedge clk_i);
    end
    do_ret(VB);
    do_pop(p);
    checks++; if (p !== VB) begin errors++; $display("FAIL bp_pop2: got %h exp %h", p, VB); end
    do_ret(VC);
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid_o !== 1'b1 || res_spin_o !== VC || res_iter_o !== 16'd2) begin
        errors++; $display("FAIL bp_res_hold%0d: valid %b spin %h iter %0d exp 1 %h 2", i, res_valid_o, res_spin_o, res_iter_o, VC); end
      @(negedge clk_i);
    end
    get_res(s, it, cv);
    checks++; if (s !== VC || it !== 16'd2) begin errors++; $display("FAIL bp_res: spin %h iter %0d exp %h 2", s, it, VC); end
  endtask

  task automatic test_flush();
    logic [NS-1:0] p;
    cfg_iter_num_i = 16'd1;
    en_i = 1'b1;
    push(VA);
    @(negedge clk_i);
    en_i = 1'b0;
    push(VB);
    push(VC);
    checks++; if (fifo_cnt_o !== 3'd2) begin errors++; $display("FAIL flush_pre_cnt: got %0d exp 2", fifo_cnt_o); end
    do_pop(p);
    checks++; if (spin_ready_o !== 1'b1) begin errors++; $display("FAIL flush_in_wait: spin_ready %b exp 1", spin_ready_o); end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || fifo_cnt_o !== 3'd0) begin
      errors++; $display("FAIL flush_state: busy %b cnt %0d exp 0 0", busy_o, fifo_cnt_o); end
    checks++; if ({spin_pop_valid_o, spin_ready_o, res_valid_o} !== 3'b0 || host_ready_o !== 1'b1 || res_iter_o !== '0) begin
      errors++; $display("FAIL flush_outs: pv %b sr %b rv %b hr %b iter %0d exp 0 0 0 1 0",
                         spin_pop_valid_o, spin_ready_o, res_valid_o, host_ready_o, res_iter_o); end
    en_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_empty: busy %b exp 0", busy_o); end
  endtask

  task automatic test_early_stop();
    logic [NS-1:0] p, s;
    logic [CB-1:0] it;
    logic cv;
    en_i = 1'b1;
`ifdef SPIN_DISPATCH_EARLY_STOP_EN
    cfg_iter_num_i = 16'd5;
    push(VA);
    do_pop(p);
    do_ret(VA);
    get_res(s, it, cv);
    checks++; if (s !== VA || it !== 16'd1 || cv !== 1'b1) begin
      errors++; $display("FAIL early_res: spin %h iter %0d conv %b exp %h 1 1", s, it, cv, VA); end
    checks++; if (res_converged_o !== 1'b0) begin errors++; $display("FAIL early_clear: conv %b exp 0", res_converged_o); end
`else
    cfg_iter_num_i = 16'd2;
    push(VA);
    do_pop(p);
    do_ret(VA);
    do_pop(p);
    checks++; if (p !== VA) begin errors++; $display("FAIL echo_pop: got %h exp %h", p, VA); end
    do_ret(VA);
    get_res(s, it, cv);
    checks++; if (it !== 16'd2 || cv !== 1'b0) begin errors++; $display("FAIL echo_res: iter %0d conv %b exp 2 0", it, cv); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_zero();
    test_fifo_full();
    test_backpressure();
    test_flush();
    test_early_stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
